// File: rtl/reg2apb_master_pkg.sv
// rtl/reg2apb_master_pkg.sv - shared constants and types for the register-to-APB initiator
package reg2apb_master_pkg;

  localparam int APB_AW = 12;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  typedef logic [APB_SW-1:0] strb_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reg2apb_master_if.sv
// rtl/reg2apb_master_if.sv - command/response and APB signal bundle for reg2apb_master
interface reg2apb_master_if #(
  parameter int AW = reg2apb_master_pkg::APB_AW,
  parameter int DW = reg2apb_master_pkg::APB_DW
) ();
  import reg2apb_master_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  strb_t         cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  strb_t         pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );

endinterface

// File: rtl/reg2apb_master_apb_wait_timer.sv
// rtl/reg2apb_master_apb_wait_timer.sv - saturating ACCESS wait-cycle counter with abort flag
module apb_wait_timer
  import reg2apb_master_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = timer_width(TIMEOUT);
  localparam logic [CW-1:0] SAT  = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_never
      assign o_expired = 1'b0;
    end else begin : g_limit
      // Fires on the wait cycle that would bring the count up to TIMEOUT.
      assign o_expired = i_enable && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/reg2apb_master.sv
// rtl/reg2apb_master.sv - APB initiator turning single register requests into SETUP/ACCESS transfers
module reg2apb_master
  import reg2apb_master_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 256
) (
  input logic              i_pclk,
  input logic              i_presetn,
  reg2apb_master_if.master io_bus
);

  localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);

  logic [1:0]    r_state;
  logic          r_cmd_ready;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  strb_t         r_pstrb;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_rsp_timeout;
  logic          w_cmd_hs;
  logic          w_wait;
  logic          w_expired;

  assign w_cmd_hs = io_bus.cmd_valid && r_cmd_ready;
  assign w_wait   = (r_state == ST_ACCESS) && !io_bus.pready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (i_pclk),
    .i_rst_n   (i_presetn),
    .i_clear   (w_cmd_hs),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // cmd_ready comes up one cycle after reset release, then stays up while idle.
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            r_pwrite    <= io_bus.cmd_write;
            r_paddr     <= io_bus.cmd_addr & ADDR_MASK;
            r_pwdata    <= io_bus.cmd_wdata;
            r_pstrb     <= io_bus.cmd_write ? io_bus.cmd_strb : '0;
            r_psel      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (io_bus.pready) begin
            r_rsp_rdata   <= (!r_pwrite && !io_bus.pslverr) ? io_bus.prdata : '0;
            r_rsp_err     <= io_bus.pslverr;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (w_expired) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.cmd_ready   = r_cmd_ready;
  assign io_bus.psel        = r_psel;
  assign io_bus.penable     = r_penable;
  assign io_bus.pwrite      = r_pwrite;
  assign io_bus.paddr       = r_paddr;
  assign io_bus.pwdata      = r_pwdata;
  assign io_bus.pstrb       = r_pstrb;
  assign io_bus.rsp_valid   = r_rsp_valid;
  assign io_bus.rsp_rdata   = r_rsp_rdata;
  assign io_bus.rsp_err     = r_rsp_err;
  assign io_bus.rsp_timeout = r_rsp_timeout;

endmodule
